// File: rtl/bus_cycle_ctl.sv
// bus_cycle_ctl: sequences one backplane bus cycle per accepted request.
// It drives db/nw/nrd with programmable per-space wait states, honours nws
// wait requests (acknowledged on nwaiting) and aborts a stuck wait after
// TO_CYCLES extended cycles.
//
// Ports:
//   clk, nreset        clock, async active-low reset
//   start              request strobe, sampled in IDLE only
//   nmem/nio, nr/nwen  space and direction selects, exactly one of each low
//   nhalt              low = halted, new requests ignored
//   wdata / db_in      write data / backplane read data
//   nws                synchronised wait request, active low
//   db_out, db_oe      registered write data and its drive enable
//   nw, nrd, nwaiting  write strobe, read strobe, wait acknowledge (active low)
//   busy, done         cycle in progress, one-cycle completion pulse
//   rdata              last captured read data
//   timeout, illegal   abort flag (with done), rejected-request pulse
module bus_cycle_ctl #(
  parameter int unsigned DW        = 16,
  parameter int unsigned MEM_WS    = 0,
  parameter int unsigned IO_WS     = 1,
  parameter int unsigned TO_CYCLES = 255
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          start,
  input  logic          nmem,
  input  logic          nio,
  input  logic          nr,
  input  logic          nwen,
  input  logic          nhalt,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] db_in,
  input  logic          nws,
  output logic [DW-1:0] db_out,
  output logic          db_oe,
  output logic          nw,
  output logic          nrd,
  output logic          nwaiting,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          timeout,
  output logic          illegal
);

  localparam int unsigned WSW = 4;
  localparam int unsigned TOW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [WSW-1:0]   ws_cnt_q, ws_cnt_d;
  logic [TOW-1:0]   to_cnt_q, to_cnt_d;
  logic             is_mem_q, is_mem_d;
  logic             is_write_q, is_write_d;
  logic [DW-1:0]    db_out_d, rdata_d;
  logic             done_d, timeout_d, illegal_d;
  logic             busy_d, db_oe_d, nw_d, nrd_d, nwaiting_d;
  logic             strobe_d;
  logic             legal_c;
  logic             to_hit_c;

  assign legal_c  = (nmem ^ nio) & (nr ^ nwen);
  // Timeout fires on the WAIT cycle whose increment reaches TO_CYCLES.
  assign to_hit_c = ((TOW + 1)'(to_cnt_q) + (TOW + 1)'(1)) == (TOW + 1)'(TO_CYCLES);

  // Next state, counters and next values of every registered output.
  always_comb begin
    state_d    = state_q;
    ws_cnt_d   = ws_cnt_q;
    to_cnt_d   = to_cnt_q;
    is_mem_d   = is_mem_q;
    is_write_d = is_write_q;
    db_out_d   = db_out;
    rdata_d    = rdata;
    done_d     = 1'b0;
    timeout_d  = 1'b0;
    illegal_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && nhalt) begin
          if (legal_c) begin
            is_mem_d   = ~nmem;
            is_write_d = ~nwen;
            db_out_d   = wdata;
            state_d    = S_SETUP;
          end else begin
            illegal_d  = 1'b1;
          end
        end
      end
      S_SETUP: begin
        ws_cnt_d = is_mem_q ? WSW'(MEM_WS) : WSW'(IO_WS);
        to_cnt_d = '0;
        state_d  = S_STROBE;
      end
      S_STROBE: begin
        if (ws_cnt_q != '0) begin
          ws_cnt_d = ws_cnt_q - WSW'(1);
        end else if (nws) begin
          state_d  = S_HOLD;
          done_d   = 1'b1;
          if (!is_write_q) rdata_d = db_in;
        end else begin
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        to_cnt_d = to_cnt_q + TOW'(1);
        // A released nws on the timeout cycle still counts as a normal finish.
        if (nws || to_hit_c) begin
          state_d   = S_HOLD;
          done_d    = 1'b1;
          timeout_d = ~nws;
          if (!is_write_q) rdata_d = db_in;
        end
      end
      S_HOLD: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    strobe_d   = (state_d == S_STROBE) || (state_d == S_WAIT);
    busy_d     = (state_d != S_IDLE);
    db_oe_d    = busy_d && is_write_d;
    nw_d       = ~(strobe_d && is_write_d);
    nrd_d      = ~(strobe_d && !is_write_d);
    nwaiting_d = ~(state_d == S_WAIT);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= S_IDLE;
      ws_cnt_q   <= '0;
      to_cnt_q   <= '0;
      is_mem_q   <= 1'b0;
      is_write_q <= 1'b0;
      db_out     <= '0;
      db_oe      <= 1'b0;
      nw         <= 1'b1;
      nrd        <= 1'b1;
      nwaiting   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      rdata      <= '0;
      timeout    <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ws_cnt_q   <= ws_cnt_d;
      to_cnt_q   <= to_cnt_d;
      is_mem_q   <= is_mem_d;
      is_write_q <= is_write_d;
      db_out     <= db_out_d;
      db_oe      <= db_oe_d;
      nw         <= nw_d;
      nrd        <= nrd_d;
      nwaiting   <= nwaiting_d;
      busy       <= busy_d;
      done       <= done_d;
      rdata      <= rdata_d;
      timeout    <= timeout_d;
      illegal    <= illegal_d;
    end
  end

endmodule

// File: tb/tb_bus_cycle_ctl.sv
// Scoreboard bench for bus_cycle_ctl. The driver derives each transaction's
// expected timing from the cycle-length rules (3 + WS + W, W = min(k, TO))
// and queues it; a negedge monitor accumulates strobe/enable widths and
// compares them whenever done or illegal appears.
module tb_bus_cycle_ctl;
  localparam int unsigned DW        = 16;
  localparam int unsigned MEM_WS    = 0;
  localparam int unsigned IO_WS     = 1;
  localparam int unsigned TO_CYCLES = 6;

  logic          clk;
  logic          nreset;
  logic          start, nmem, nio, nr, nwen, nhalt, nws;
  logic [DW-1:0] wdata, db_in;
  logic [DW-1:0] db_out, rdata;
  logic          db_oe, nw, nrd, nwaiting, busy, done, timeout, illegal;

  bus_cycle_ctl #(
    .DW(DW), .MEM_WS(MEM_WS), .IO_WS(IO_WS), .TO_CYCLES(TO_CYCLES)
  ) dut (
    .clk(clk), .nreset(nreset), .start(start), .nmem(nmem), .nio(nio),
    .nr(nr), .nwen(nwen), .nhalt(nhalt), .wdata(wdata), .db_in(db_in),
    .nws(nws), .db_out(db_out), .db_oe(db_oe), .nw(nw), .nrd(nrd),
    .nwaiting(nwaiting), .busy(busy), .done(done), .rdata(rdata),
    .timeout(timeout), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit            is_ill;
    bit            is_write;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            len;
    int            strobe;
    int            waitc;
    bit            tmo;
  } exp_t;

  exp_t          sb[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] last_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: widths since the last done, compared against the queued entry.
  int   c_busy, c_nw, c_nrd, c_wait, c_oe, c_dbok;
  exp_t m;
  always @(negedge clk) begin
    if (!nreset) begin
      c_busy = 0; c_nw = 0; c_nrd = 0; c_wait = 0; c_oe = 0; c_dbok = 0;
    end else begin
      if (busy)      c_busy++;
      if (!nw)       c_nw++;
      if (!nrd)      c_nrd++;
      if (!nwaiting) c_wait++;
      if (db_oe)     c_oe++;
      if (db_oe && sb.size() > 0 && db_out === sb[0].wdata) c_dbok++;
      if (done || illegal) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: done=%0b illegal=%0b, none expected", done, illegal);
        end else begin
          m = sb.pop_front();
          if (m.is_ill) begin
            chk("illegal_pulse", illegal, 1);
            chk("illegal_busy",  busy,    0);
          end else begin
            chk("done_pulse",  done,   1);
            chk("cycle_len",   c_busy, m.len);
            chk("nw_width",    c_nw,   m.is_write ? m.strobe : 0);
            chk("nrd_width",   c_nrd,  m.is_write ? 0 : m.strobe);
            chk("nwaiting_w",  c_wait, m.waitc);
            chk("db_oe_width", c_oe,   m.is_write ? m.len : 0);
            if (m.is_write) chk("db_out_held", c_dbok, m.len);
            chk("timeout",     timeout, m.tmo);
            chk("rdata",       rdata,   m.rdata);
            c_busy = 0; c_nw = 0; c_nrd = 0; c_wait = 0; c_oe = 0; c_dbok = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      nws   = 1'($urandom);
      db_in = DW'($urandom);
      tick();
    end
  endtask

  // One accepted transaction; k = consecutive nws-low samples from the
  // last STROBE cycle onward. chaos scribbles start/nhalt/selects while busy.
  task automatic run_txn(input bit is_mem, input bit is_write, input logic [DW-1:0] wd,
                         input int k, input logic [DW-1:0] capv, input bit chaos);
    int   ws, w, ecap, j;
    exp_t e;
    ws   = is_mem ? int'(MEM_WS) : int'(IO_WS);
    w    = (k < int'(TO_CYCLES)) ? k : int'(TO_CYCLES);
    ecap = ws + 2 + w;
    if (!is_write) last_rdata = capv;
    e.is_ill   = 1'b0;
    e.is_write = is_write;
    e.wdata    = wd;
    e.rdata    = last_rdata;
    e.len      = 3 + ws + w;
    e.strobe   = ws + 1 + w;
    e.waitc    = w;
    e.tmo      = (k > int'(TO_CYCLES));
    sb.push_back(e);
    start = 1'b1; nhalt = 1'b1;
    nmem  = ~is_mem; nio = is_mem; nr = is_write; nwen = ~is_write;
    wdata = wd; nws = 1'($urandom); db_in = DW'($urandom);
    tick();
    for (int ed = 1; ed <= ecap + 1; ed++) begin
      if (chaos) begin
        start = 1'($urandom);
        nhalt = 1'($urandom);
        {nmem, nio, nr, nwen} = 4'($urandom);
        wdata = DW'($urandom);
      end else begin
        start = 1'b0;
      end
      db_in = (ed == ecap) ? capv : (capv ^ DW'($urandom_range(1, 65535)));
      j = ed - ws - 2;
      if (j < 0 || j > w) nws = 1'($urandom);
      else                nws = (j < k) ? 1'b0 : 1'b1;
      tick();
    end
    start = 1'b0;
    nhalt = 1'b1;
  endtask

  task automatic run_illegal();
    logic [3:0] l;
    exp_t       e;
    do l = 4'($urandom); while ((l[3] ^ l[2]) && (l[1] ^ l[0]));
    e = '{default: 0};
    e.is_ill = 1'b1;
    sb.push_back(e);
    start = 1'b1; nhalt = 1'b1;
    {nmem, nio, nr, nwen} = l;
    tick();
    start = 1'b0;
  endtask

  task automatic run_halted();
    start = 1'b1; nhalt = 1'b0;
    nmem = 1'($urandom); nio = ~nmem; nr = 1'($urandom); nwen = ~nr;
    tick();
    start = 1'b0; nhalt = 1'b1;
    chk("halted_busy", busy, 0);
  endtask

  initial begin
    nreset = 1'b0; start = 1'b0; nmem = 1'b1; nio = 1'b1; nr = 1'b1; nwen = 1'b1;
    nhalt = 1'b1; nws = 1'b1; wdata = '0; db_in = '0; last_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_nw", nw, 1);          chk("rst_nrd", nrd, 1);
    chk("rst_nwaiting", nwaiting, 1);
    chk("rst_db_oe", db_oe, 0);    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);      chk("rst_timeout", timeout, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_db_out", db_out, 0);  chk("rst_rdata", rdata, 0);
    @(posedge clk); #1 nreset = 1'b1;
    idle(2);

    // Directed cases: zero-wait write, 1-WS read, extended waits, timeout edge.
    run_txn(1'b1, 1'b1, DW'(16'hA55A), 0, DW'($urandom), 1'b0);
    idle(1);
    run_txn(1'b0, 1'b0, DW'($urandom), 0, DW'(16'h1234), 1'b0);
    run_txn(1'b1, 1'b0, DW'($urandom), 5, DW'(16'hBEEF), 1'b0);
    run_txn(1'b1, 1'b0, DW'($urandom), int'(TO_CYCLES), DW'(16'h0F0F), 1'b0);
    run_txn(1'b0, 1'b0, DW'($urandom), int'(TO_CYCLES) + 3, DW'(16'hC0DE), 1'b0);
    run_txn(1'b1, 1'b1, DW'(16'h7E57), 2, DW'($urandom), 1'b0);
    run_illegal();
    run_halted();
    idle(1);

    // Randomised mix of legal, illegal and halted requests.
    for (int it = 0; it < 80; it++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op == 0)      run_illegal();
      else if (op == 1) run_halted();
      else run_txn(1'($urandom), 1'($urandom), DW'($urandom),
                   int'($urandom_range(0, TO_CYCLES + 2)), DW'($urandom), 1'($urandom));
      idle(int'($urandom_range(0, 2)));
    end

    // Drain outstanding expectations.
    for (int i = 0; i < 30 && sb.size() != 0; i++) tick();
    chk("drain_empty", sb.size(), 0);

    // Asynchronous reset while a write sits in WAIT.
    start = 1'b1; nhalt = 1'b1; nmem = 1'b0; nio = 1'b1; nr = 1'b1; nwen = 1'b0;
    wdata = DW'(16'h5AA5); nws = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_nw", nw, 0);
    chk("pre_rst_nwaiting", nwaiting, 0);
    chk("pre_rst_db_oe", db_oe, 1);
    #2 nreset = 1'b0;
    #1;
    chk("arst_nw", nw, 1);
    chk("arst_nrd", nrd, 1);
    chk("arst_nwaiting", nwaiting, 1);
    chk("arst_db_oe", db_oe, 0);
    sb.delete();
    last_rdata = '0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 nreset = 1'b1;
    nws = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_rdata", rdata, 0);
    run_txn(1'b0, 1'b0, DW'($urandom), 1, DW'(16'h4321), 1'b0);
    idle(2);
    chk("final_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
